// File: rtl/ecg_pkg.sv
// ---------------------------------------------------------------------------
// ecg_pkg
//   Shared constants for the ECG ping-pong capture path: default widths,
//   writer FSM state encoding and bank identifiers. Imported by the writer
//   and by the bank tracker so both sides agree on what bank 0/1 means.
// ---------------------------------------------------------------------------
package ecg_pkg;

  localparam int ECG_DATA_W = 12;
  localparam int ECG_ADDR_W = 12;
  localparam int ECG_DROP_W = 16;

  // Writer FSM encoding. Kept as plain constants so the encoding stays
  // stable for older tools and hand-written checkers that decode it.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

endpackage

// File: rtl/ecg_bank_tracker.sv
// ---------------------------------------------------------------------------
// ecg_bank_tracker
//   Book-keeping for the two ping-pong banks: which banks hold a complete,
//   unread frame and which bank the reader must take next.
//   A release (i_drc) frees the bank at rd_bank and advances rd_bank; a
//   release with no full bank is ignored. A release is applied before a set
//   in the same cycle, so a bank freed this cycle reads as free at once.
//
//   Ports
//     clk, rst_n    clock, asynchronous active-low reset
//     i_set         a frame completed this cycle in bank i_set_bank
//     i_set_bank    bank that just completed
//     i_drc         reader finished the bank at o_rd_bank
//     o_rd_bank     oldest full bank (next to read)
//     o_full_rel    full flags after this cycle's release, before any set
// ---------------------------------------------------------------------------
module ecg_bank_tracker
  import ecg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_set,
  input  logic       i_set_bank,
  input  logic       i_drc,
  output logic       o_rd_bank,
  output logic [1:0] o_full_rel
);

  logic [1:0] r_full;
  logic       r_rd_bank;
  logic       w_release;
  logic [1:0] w_full_rel;
  logic [1:0] w_full_nxt;

  assign w_release = i_drc && (r_full != 2'b00);

  always_comb begin
    // NOTE: every variable gets its default before any conditional update,
    // so no path leaves it unassigned and no latch is inferred.
    w_full_rel = r_full;
    if (w_release) w_full_rel[r_rd_bank] = 1'b0;
    w_full_nxt = w_full_rel;
    if (i_set) w_full_nxt[i_set_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full    <= 2'b00;
      r_rd_bank <= BANK_A;
    end else begin
      r_full <= w_full_nxt;
      if (w_release) r_rd_bank <= ~r_rd_bank;
    end
  end

  assign o_rd_bank  = r_rd_bank;
  assign o_full_rel = w_full_rel;

endmodule

// File: rtl/ecg_pingpong_writer.sv
// ---------------------------------------------------------------------------
// ecg_pingpong_writer
//   Captures a non-stallable ADC sample stream into two BRAM banks (A/B) in
//   ping-pong order. When a bank holds a complete frame, dc pulses and the
//   writer moves to the other bank. If that bank has not yet been released
//   by the reader (drc), the writer waits and drops incoming samples,
//   counting them in a saturating counter.
//
//   Ports
//     clk, rst_n   clock, asynchronous active-low reset
//     load         frame length in samples, 0 = 2**ADDR_W; latched per frame
//     s_valid      sample strobe
//     s_data       sample value
//     drc          reader done with the bank at rd_bank (1-cycle pulse)
//     wea, web     registered write enables for bank A / bank B
//     addr_w, din  registered write address / data, shared by both banks
//     dc           1-cycle pulse, a frame is ready in bank rd_bank
//     rd_bank      bank the reader must take next (0=A, 1=B)
//     wr_bank      bank currently being filled
//     s_ready      a sample arriving this cycle will be stored
//     drop_cnt     saturating count of dropped samples
// ---------------------------------------------------------------------------
module ecg_pingpong_writer
  import ecg_pkg::*;
#(
  parameter int DATA_W = ECG_DATA_W,
  parameter int ADDR_W = ECG_ADDR_W,
  parameter int DROP_W = ECG_DROP_W
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] load,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              drc,
  output logic              wea,
  output logic              web,
  output logic [ADDR_W-1:0] addr_w,
  output logic [DATA_W-1:0] din,
  output logic              dc,
  output logic              rd_bank,
  output logic              wr_bank,
  output logic              s_ready,
  output logic [DROP_W-1:0] drop_cnt
);

  // One extra bit so a full 2**ADDR_W frame length is representable.
  localparam int LEN_W = ADDR_W + 1;

  logic [1:0]        r_state;
  logic [LEN_W-1:0]  r_len;
  logic [ADDR_W-1:0] r_idx;
  logic              r_wr_bank;
  logic              r_wea;
  logic              r_web;
  logic [ADDR_W-1:0] r_addr_w;
  logic [DATA_W-1:0] r_din;
  logic              r_dc_pend;
  logic              r_dc;
  logic [DROP_W-1:0] r_drop;

  logic              w_accept;
  logic              w_last;
  logic              w_drop;
  logic [LEN_W-1:0]  w_load_len;
  logic [1:0]        w_full_rel;
  logic              w_rd_bank;

  assign w_load_len = (load == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, load};
  assign w_accept   = (r_state == FILL) && s_valid;
  assign w_last     = w_accept && ({1'b0, r_idx} == (r_len - LEN_W'(1)));
  assign w_drop     = (r_state == WAIT) && s_valid;

  ecg_bank_tracker u_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_set      (w_last),
    .i_set_bank (r_wr_bank),
    .i_drc      (drc),
    .o_rd_bank  (w_rd_bank),
    .o_full_rel (w_full_rel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_len     <= {1'b1, {ADDR_W{1'b0}}};
      r_idx     <= '0;
      r_wr_bank <= BANK_A;
      r_wea     <= 1'b0;
      r_web     <= 1'b0;
      r_addr_w  <= '0;
      r_din     <= '0;
      r_dc_pend <= 1'b0;
      r_dc      <= 1'b0;
      r_drop    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      r_wea <= w_accept && (r_wr_bank == BANK_A);
      r_web <= w_accept && (r_wr_bank == BANK_B);
      if (w_accept) begin
        r_addr_w <= r_idx;
        r_din    <= s_data;
      end

      // Two-stage delay keeps dc clear of the cycle that carries the last
      // write of the frame on the bus.
      r_dc_pend <= w_last;
      r_dc      <= r_dc_pend;

      if (w_drop && (r_drop != '1)) r_drop <= r_drop + DROP_W'(1);

      case (r_state)
        IDLE: begin
          r_state <= FILL;
          r_len   <= w_load_len;
          r_idx   <= '0;
        end
        FILL: begin
          if (w_accept) begin
            if (w_last) begin
              r_idx     <= '0;
              r_len     <= w_load_len;
              r_wr_bank <= ~r_wr_bank;
              // Release is already folded into w_full_rel, so a bank freed
              // by a coincident drc is refilled without a WAIT.
              r_state   <= w_full_rel[~r_wr_bank] ? WAIT : FILL;
            end else begin
              r_idx <= r_idx + ADDR_W'(1);
            end
          end
        end
        WAIT: begin
          if (!w_full_rel[r_wr_bank]) r_state <= FILL;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wea      = r_wea;
  assign web      = r_web;
  assign addr_w   = r_addr_w;
  assign din      = r_din;
  assign dc       = r_dc;
  assign rd_bank  = w_rd_bank;
  assign wr_bank  = r_wr_bank;
  assign s_ready  = (r_state == FILL);
  assign drop_cnt = r_drop;

endmodule

// File: tb/tb_ecg_pingpong_writer.sv
// ---------------------------------------------------------------------------
// tb_ecg_pingpong_writer
//   Directed sequence with randomized sample data and reader timing. Expected
//   outputs come from a frame-level model: a FIFO of full banks in write
//   order, the bank being filled, the fill position and a drop counter.
// ---------------------------------------------------------------------------
module tb_ecg_pingpong_writer;

  localparam int DATA_W = 12;
  localparam int ADDR_W = 12;
  localparam int DROP_W = 16;
  localparam int DROP_MAX = 65535;

  typedef struct packed {
    logic              wea;
    logic              web;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic              dc;
    logic              rd;
    logic              wr;
    logic              rdy;
    logic [DROP_W-1:0] drop;
  } obs_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] load = '0;
  logic              s_valid = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              drc = 1'b0;
  logic              wea, web, dc, rd_bank, wr_bank, s_ready;
  logic [ADDR_W-1:0] addr_w;
  logic [DATA_W-1:0] din;
  logic [DROP_W-1:0] drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  ecg_pingpong_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DROP_W(DROP_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .drc      (drc),
    .wea      (wea),
    .web      (web),
    .addr_w   (addr_w),
    .din      (din),
    .dc       (dc),
    .rd_bank  (rd_bank),
    .wr_bank  (wr_bank),
    .s_ready  (s_ready),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int   full_q[$];      // banks holding unread frames, oldest first
  bit   m_started;      // first cycle after reset has passed
  bit   m_wait;         // no free bank to fill
  int   m_wr, m_rd, m_pos, m_len, m_drop;
  obs_t m_out;          // expected registered outputs
  bit   m_dc_next;      // frame completed, dc due one cycle later
  bit   last_drc;
  bit   seen_top_addr;

  function automatic bit is_full(input int b);
    foreach (full_q[i]) if (full_q[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int len_of(input logic [ADDR_W-1:0] l);
    return (l == 0) ? (1 << ADDR_W) : int'(l);
  endfunction

  task automatic model_reset();
    full_q.delete();
    m_started = 0; m_wait = 0;
    m_wr = 0; m_rd = 0; m_pos = 0; m_len = 0; m_drop = 0;
    m_out = '0; m_dc_next = 0; last_drc = 0;
  endtask

  // Advance the model across one clock edge with the given inputs.
  task automatic model_edge(input bit v, input logic [DATA_W-1:0] d, input bit r);
    bit completed = 0;
    if (r && full_q.size() > 0) begin
      void'(full_q.pop_front());
      m_rd = 1 - m_rd;
    end
    m_out.wea = 0;
    m_out.web = 0;
    if (!m_started) begin
      m_started = 1;
      m_len = len_of(load);
      m_pos = 0;
    end else if (!m_wait) begin
      if (v) begin
        m_out.wea  = (m_wr == 0);
        m_out.web  = (m_wr == 1);
        m_out.addr = ADDR_W'(m_pos);
        m_out.din  = d;
        if (m_pos == m_len - 1) begin
          full_q.push_back(m_wr);
          completed = 1;
          m_wr  = 1 - m_wr;
          m_pos = 0;
          m_len = len_of(load);
          m_wait = is_full(m_wr);
        end else begin
          m_pos++;
        end
      end
    end else begin
      if (v && m_drop < DROP_MAX) m_drop++;
      if (!is_full(m_wr)) m_wait = 0;
    end
    m_out.dc   = m_dc_next;
    m_dc_next  = completed;
    m_out.rd   = m_rd[0];
    m_out.wr   = m_wr[0];
    m_out.rdy  = m_started && !m_wait;
    m_out.drop = DROP_W'(m_drop);
  endtask

  // ---------------- checking ----------------
  function automatic obs_t observe();
    obs_t o;
    o.wea = wea; o.web = web; o.addr = addr_w; o.din = din; o.dc = dc;
    o.rd = rd_bank; o.wr = wr_bank; o.rdy = s_ready; o.drop = drop_cnt;
    return o;
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit v, input bit r, input string tag);
    logic [DATA_W-1:0] d;
    d = DATA_W'($urandom);
    s_valid = v; s_data = d; drc = r;
    model_edge(v, d, r);
    last_drc = r;
    @(posedge clk); #1;
    if ((wea || web) && addr_w == '1) seen_top_addr = 1;
    check(tag, observe(), m_out);
  endtask

  task automatic run(input int n, input int pv, input int pd, input string tag);
    for (int i = 0; i < n; i++) begin
      bit v, r;
      v = ($urandom % 100) < pv;
      r = !last_drc && (($urandom % 100) < pd);
      step(v, r, tag);
    end
  endtask

  // Reset applied away from any clock edge; outputs must clear at once.
  task automatic do_reset();
    s_valid = 0; drc = 0;
    #2 rst_n = 0;
    #1 check("async_reset", observe(), '0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    seen_top_addr = 0;
    model_reset();

    // 1: one 10-sample frame into bank A, plus a drc with nothing full
    load = 10;
    do_reset();
    step(0, 0, "idle_cycle");
    step(0, 1, "drc_empty_ignored");
    for (int i = 0; i < 10; i++) step(1, 0, "frame_a");
    step(0, 0, "dc_gap");
    step(0, 0, "dc_after_a");
    check_int("rd_bank_after_a", int'(rd_bank), 0);
    check_int("wr_bank_after_a", int'(wr_bank), 1);

    // 2: bank B, then no free bank -> drop, then drc frees A
    for (int i = 0; i < 10; i++) step(1, 0, "frame_b");
    step(1, 0, "drop_one");
    check_int("drop_cnt_one", int'(drop_cnt), 1);
    step(0, 1, "drc_release_a");
    step(1, 0, "refill_a_addr0");
    check_int("refill_a_wea", int'(wea), 1);
    check_int("refill_a_addr", int'(addr_w), 0);

    // 3: drc coincides with the last write of A while B is still full
    for (int i = 0; i < 8; i++) step(1, 0, "frame_a2");
    step(1, 1, "last_write_with_drc");
    step(1, 0, "no_wait_b_addr0");
    check_int("coincident_web", int'(web), 1);
    check_int("coincident_addr", int'(addr_w), 0);
    check_int("coincident_no_drop", int'(drop_cnt), 1);

    // 4: full-size frames, then a mid-frame length change
    load = 0;
    run(2000, 100, 50, "len_4096_a");
    load = 5;
    run(2500, 100, 50, "len_4096_b");
    run(60, 70, 40, "len_5_random");
    check_int("saw_addr_4095", int'(seen_top_addr), 1);

    // 5: reset at addr 6 of bank B with A full
    load = 10;
    do_reset();
    step(0, 0, "idle_cycle2");
    for (int i = 0; i < 10; i++) step(1, 0, "pre_a");
    for (int i = 0; i < 7; i++) step(1, 0, "pre_b");
    check_int("pre_reset_addr", int'(addr_w), 6);
    do_reset();
    step(0, 0, "idle_cycle3");
    step(1, 0, "post_reset_first");
    check_int("post_reset_wea", int'(wea), 1);
    check_int("post_reset_addr", int'(addr_w), 0);

    // 6: long WAIT saturates drop_cnt, drc then recovers filling
    for (int i = 0; i < 19; i++) step(1, 0, "fill_both");
    for (int i = 0; i < 70000; i++) step(1, 0, "wait_drop");
    check_int("drop_saturated", int'(drop_cnt), DROP_MAX);
    step(0, 1, "drc_recover");
    run(30, 80, 30, "recovered");
    check_int("drop_still_saturated", int'(drop_cnt), DROP_MAX);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
